gxsim_reg_access_master: RTL and testbench
==========================================

# gxsim_reg_access_master

Initiator side of the GenX simulator's bank-register bus. Consumes the decoded byte stream of one QSPI transaction frame (command, address, data), and drives the shared register interface (address, wdata, write_strobe, per-bank select) that every simulated bank register/SMEM block responds to. For reads, it fetches the selected bank's rdata and returns it as a byte stream toward the QSPI transmitter.

## Interface
- NUM_BANKS, 4: number of attached banks (1..16).
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- frame_active  in  1  high while QSPI chip-select is asserted; a falling edge ends the transaction.
- rx_byte  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_byte valid.
- tx_byte  out  8  read-data byte toward the transmitter.
- tx_valid  out  1  tx_byte valid; held until accepted.
- tx_ready  in  1  transmitter accepts tx_byte when tx_valid & tx_ready.
- address  out  32  byte address presented to the banks.
- wdata  out  32  write data presented to the banks.
- write_strobe  out  1  one-cycle write pulse, common to all banks.
- bank_select  out  NUM_BANKS  one-hot bank enable.
- bank_rdata  in  32*NUM_BANKS  flattened rdata; bank i at [32i+31:32i].

## Operation
- Frame format: command byte, 4 address bytes MSB-first, then data words of 4 bytes MSB-first.
- Command byte: bit7 = 1 read / 0 write; bits[3:0] = bank index; bits[6:4] ignored.
- States: IDLE, ADDR, WDATA, RLOAD, RSEND, DRAIN.
- IDLE: first rx_valid with frame_active high latches the command. A bank index below NUM_BANKS drives bank_select one-hot -> ADDR. An index of NUM_BANKS or above -> DRAIN.
- ADDR: shift 4 bytes into address. After the 4th byte: write -> WDATA; read -> RLOAD.
- WDATA: shift bytes into wdata. On every 4th byte, pulse write_strobe for one cycle, then add 4 to address on the following cycle. Unlimited burst length.
- RLOAD: latch the selected bank's rdata into a 32-bit shift register -> RSEND.
- RSEND: present bytes MSB-first with valid/ready. After the 4th byte is accepted, add 4 to address -> RLOAD. Any rx bytes received in RLOAD/RSEND are dummy bytes and are discarded.
- DRAIN: ignore everything. No write_strobe, no tx_valid.
- frame_active low in any state -> IDLE next cycle. That clears bank_select, tx_valid, and the byte counter. A partial write word (fewer than 4 bytes) is discarded with no strobe. A pending tx byte is dropped.
- address, wdata: retain their last values in IDLE (not cleared).
- Address arithmetic: 32-bit modulo; 0xFFFF_FFFC + 4 = 0x0000_0000.

## Timing
- Reset values: address 0, wdata 0, write_strobe 0, bank_select 0, tx_byte 0, tx_valid 0; state IDLE.
- Write: write_strobe is high in the cycle after the 4th data byte's rx_valid. address and wdata are stable in that cycle, and address increments in the cycle after it.
- Read: the first tx_valid occurs 2 cycles after the 4th address byte's rx_valid (1 cycle to RLOAD, 1 cycle to latch). Between words there are 2 cycles from the last accepted byte to the next tx_valid.
- tx_byte/tx_valid change only after acceptance or abort. They never change while tx_valid & !tx_ready.
- rx_valid and frame_active falling in the same cycle: the byte is discarded and the frame aborts.
- Asynchronous reset mid-frame: all outputs go to their reset values immediately, and any in-progress write does not strobe.

## Structure
- gxsim_reg_pkg (shared): command bit positions (CMD_READ_BIT=7, CMD_BANK_MSB=3), state encoding, ADDR_STRIDE=4.
- No sub-module; the byte shifting and the FSM fit in one module. The bank_rdata mux is inline.

## Test plan
- Write to bank 1: cmd 0x01, addr 00 00 00 10, data DE AD BE EF -> one write_strobe with address=0x10, wdata=0xDEADBEEF, bank_select=0b0010.
- Burst read from bank 2 at 0x20, with bank model rdata = address+1 -> tx bytes 00 00 00 21 00 00 00 25, with tx_ready toggled randomly and no byte lost or duplicated.
- Bad bank: cmd 0x07 with NUM_BANKS=4, followed by 8 bytes -> no write_strobe, no tx_valid, bank_select stays 0.
- Abort: write with 2 data bytes, then frame_active low -> no strobe, IDLE, bank_select 0. The next frame then works normally.
- Wrap: write burst of 2 words at 0xFFFFFFFC -> strobes at 0xFFFFFFFC, then at 0x00000000.
- resetn asserted in RSEND with tx_valid high -> tx_valid 0 and address 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/gxsim_reg_pkg.sv
// gxsim_reg_pkg: shared command-byte layout, FSM encoding and address stride for the bank-register bus
package gxsim_reg_pkg;
  localparam int CMD_READ_BIT = 7;
  localparam int CMD_BANK_MSB = 3;
  localparam logic [31:0] ADDR_STRIDE = 32'd4;
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RLOAD, RSEND, DRAIN} state_t;
endpackage

// File: rtl/gxsim_reg_access_master.sv
// gxsim_reg_access_master: turns a decoded QSPI frame byte stream into bank register writes and read-data bytes
// Ports: clk/resetn (async active-low); frame_active, rx_byte, rx_valid from the QSPI receiver;
// tx_byte, tx_valid, tx_ready toward the transmitter; address, wdata, write_strobe, bank_select
// drive the shared bank interface; bank_rdata is every bank's read data, bank i at [32i+31:32i].
module gxsim_reg_access_master
  import gxsim_reg_pkg::*;
#(
  parameter int NUM_BANKS = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   frame_active,
  input  logic [7:0]             rx_byte,
  input  logic                   rx_valid,
  output logic [7:0]             tx_byte,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [31:0]            address,
  output logic [31:0]            wdata,
  output logic                   write_strobe,
  output logic [NUM_BANKS-1:0]   bank_select,
  input  logic [32*NUM_BANKS-1:0] bank_rdata
);
  state_t state, state_nx;
  logic [1:0] cnt;
  logic rd;
  logic [31:0] sreg, rdata_sel;
  logic rx, acc, bank_ok;
  assign rx = frame_active & rx_valid;
  assign acc = tx_valid & tx_ready;
  assign bank_ok = 32'(rx_byte[CMD_BANK_MSB:0]) < NUM_BANKS;
  // tx_byte is the top of the read shift register; it only moves on acceptance or a new load
  assign tx_byte = sreg[31:24];
  // bank_select is one-hot, so the rdata mux just picks the enabled bank
  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NUM_BANKS; i++)
      if (bank_select[i]) rdata_sel = bank_rdata[32*i +: 32];
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (!frame_active) state_nx = IDLE;
    else case (state)
      IDLE:  if (rx_valid) state_nx = bank_ok ? ADDR : DRAIN;
      ADDR:  if (rx_valid && cnt == 2'd3) state_nx = rd ? RLOAD : WDATA;
      RLOAD: state_nx = RSEND;
      RSEND: if (acc && cnt == 2'd3) state_nx = RLOAD;
      default: state_nx = state;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      address      <= '0;
      wdata        <= '0;
      write_strobe <= 1'b0;
      bank_select  <= '0;
      tx_valid     <= 1'b0;
      sreg         <= '0;
      cnt          <= '0;
      rd           <= 1'b0;
    end else begin
      // a byte arriving as the frame drops is discarded, so a word completed then never strobes
      write_strobe <= state == WDATA && rx && cnt == 2'd3;
      if (!frame_active) begin
        bank_select <= '0;
        tx_valid    <= 1'b0;
        cnt         <= '0;
      end else case (state)
        IDLE: if (rx_valid) begin
          rd          <= rx_byte[CMD_READ_BIT];
          cnt         <= '0;
          bank_select <= bank_ok ? NUM_BANKS'(1) << rx_byte[CMD_BANK_MSB:0] : '0;
        end
        ADDR: if (rx_valid) begin
          address <= {address[23:0], rx_byte};
          cnt     <= cnt + 2'd1;
        end
        WDATA: if (rx_valid) begin
          wdata <= {wdata[23:0], rx_byte};
          cnt   <= cnt + 2'd1;
        end
        RLOAD: begin
          sreg     <= rdata_sel;
          tx_valid <= 1'b1;
          cnt      <= '0;
        end
        RSEND: if (acc) begin
          sreg <= sreg << 8;
          cnt  <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            tx_valid <= 1'b0;
            address  <= address + ADDR_STRIDE;
          end
        end
        default: ;
      endcase
      // the write address advances in the cycle after its strobe
      if (write_strobe) address <= address + ADDR_STRIDE;
    end
endmodule

// File: tb/tb_gxsim_reg_access_master.sv
// tb_gxsim_reg_access_master: randomized frame stimulus checked against a transaction-level model
module tb_gxsim_reg_access_master;
  localparam int NB = 4;
  logic clk = 1'b0, resetn = 1'b0, frame_active = 1'b0, rx_valid = 1'b0, tx_ready = 1'b0;
  logic [7:0] rx_byte = '0, tx_byte;
  logic tx_valid, write_strobe;
  logic [31:0] address, wdata;
  logic [NB-1:0] bank_select, sel_seen;
  logic [32*NB-1:0] bank_rdata;
  int errors = 0, checks = 0, tx_cnt = 0, hold_viol = 0;
  logic hold_v = 1'b0;
  logic [7:0] hold_b = '0;
  logic [31:0] got_a[$], got_d[$], exp_a[$], exp_d[$];
  logic [NB-1:0] got_s[$], exp_s[$];
  logic [7:0] got_tx[$], exp_tx[$];

  gxsim_reg_access_master #(.NUM_BANKS(NB)) dut (
    .clk(clk), .resetn(resetn), .frame_active(frame_active), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .address(address), .wdata(wdata), .write_strobe(write_strobe),
    .bank_select(bank_select), .bank_rdata(bank_rdata));

  always #5 clk = ~clk;

  // bank model: bank 2 returns address+1, the others differ in the top nibble
  always_comb
    for (int i = 0; i < NB; i++)
      bank_rdata[32*i +: 32] = (address + 32'd1) ^ (32'(i ^ 2) << 28);

  // observation only: record strobes and accepted bytes, and note any held byte that moved
  always @(negedge clk)
    if (resetn) begin
      if (write_strobe) begin
        got_a.push_back(address);
        got_d.push_back(wdata);
        got_s.push_back(bank_select);
      end
      if (tx_valid && tx_ready) got_tx.push_back(tx_byte);
      if (tx_valid) tx_cnt++;
      sel_seen = sel_seen | bank_select;
      if (hold_v && frame_active && (tx_valid !== 1'b1 || tx_byte !== hold_b)) hold_viol++;
      hold_v = tx_valid && !tx_ready;
      hold_b = tx_byte;
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    got_a.delete(); got_d.delete(); got_s.delete(); got_tx.delete();
    exp_a.delete(); exp_d.delete(); exp_s.delete(); exp_tx.delete();
  endtask

  task automatic send(input logic [7:0] b);
    repeat ($urandom_range(0, 1)) tick;
    rx_byte = b;
    rx_valid = 1'b1;
    tick;
    rx_valid = 1'b0;
  endtask

  // model: every complete 4-byte word of a valid-bank write frame is one strobe at base+4k
  task automatic wr_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] w0,
                          input int nbytes, input bit close);
    logic [31:0] w, fixed;
    logic [7:0] b;
    clr();
    fixed = w0;
    w = '0;
    frame_active = 1'b1;
    send(cmd);
    for (int i = 0; i < 4; i++) send(addr[31-8*i -: 8]);
    for (int i = 0; i < nbytes; i++) begin
      b = i < 4 ? fixed[31-8*i -: 8] : 8'($urandom);
      send(b);
      w = {w[23:0], b};
      if (i % 4 == 3 && cmd[7] == 1'b0 && int'(cmd[3:0]) < NB) begin
        exp_a.push_back(addr + 32'(4 * (i / 4)));
        exp_d.push_back(w);
        exp_s.push_back(NB'(1) << cmd[3:0]);
      end
    end
    if (close) begin
      tick; tick;
      frame_active = 1'b0;
      tick; tick;
    end
  endtask

  // model: word k of a read burst is bank(base+4k), sent MSB first
  task automatic rd_frame(input logic [3:0] bank, input logic [31:0] addr, input int nw);
    logic [31:0] w;
    int t;
    clr();
    tx_ready = 1'b0;
    frame_active = 1'b1;
    send({4'h8, bank});
    for (int i = 0; i < 4; i++) send(addr[31-8*i -: 8]);
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL rd_latency_early: tx_valid=%b want 0", tx_valid); end
    tick;
    checks++;
    if (tx_valid !== 1'b1) begin errors++; $display("FAIL rd_latency: tx_valid=%b want 1", tx_valid); end
    for (int k = 0; k < nw; k++) begin
      w = (addr + 32'(4 * k) + 32'd1) ^ (32'(bank ^ 4'd2) << 28);
      for (int i = 0; i < 4; i++) exp_tx.push_back(w[31-8*i -: 8]);
    end
    t = 0;
    while (got_tx.size() < 4 * nw && t < 400) begin
      tx_ready = 1'($urandom_range(0, 1));
      rx_valid = 1'($urandom_range(0, 1));
      rx_byte = 8'($urandom);
      tick;
      t++;
    end
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    frame_active = 1'b0;
    checks++;
    if (t >= 400) begin errors++; $display("FAIL rd_timeout: got %0d bytes want %0d", got_tx.size(), 4 * nw); end
    tick; tick;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    #12;
    checks++;
    if ({address, wdata, write_strobe, bank_select, tx_byte, tx_valid} !== '0) begin
      errors++;
      $display("FAIL reset_values: addr=%h wdata=%h ws=%b sel=%b txb=%h txv=%b want all 0",
               address, wdata, write_strobe, bank_select, tx_byte, tx_valid);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    tick;
  endtask

  task automatic test_write;
    wr_frame(8'h01, 32'h10, 32'hDEADBEEF, 4, 1'b0);
    checks++;
    if (write_strobe !== 1'b1 || address !== 32'h10 || wdata !== 32'hDEADBEEF || bank_select !== 4'b0010) begin
      errors++;
      $display("FAIL write_strobe_cycle: ws=%b addr=%h wdata=%h sel=%b want 1 00000010 deadbeef 0010",
               write_strobe, address, wdata, bank_select);
    end
    tick;
    checks++;
    if (write_strobe !== 1'b0 || address !== 32'h14) begin
      errors++;
      $display("FAIL write_addr_inc: ws=%b addr=%h want 0 00000014", write_strobe, address);
    end
    frame_active = 1'b0;
    tick; tick;
    checks++;
    if (got_a.size() != 1 || bank_select !== '0) begin
      errors++;
      $display("FAIL write_count: strobes=%0d sel=%b want 1 0000", got_a.size(), bank_select);
    end
  endtask

  task automatic test_read;
    rd_frame(4'd2, 32'h20, 2);
    checks++;
    if (got_tx.size() != 8) begin
      errors++;
      $display("FAIL read_count: got %0d bytes want 8", got_tx.size());
    end else foreach (exp_tx[i]) begin
      checks++;
      if (got_tx[i] !== exp_tx[i]) begin errors++; $display("FAIL read_byte%0d: got %h want %h", i, got_tx[i], exp_tx[i]); end
    end
    checks++;
    if (hold_viol != 0) begin errors++; $display("FAIL read_hold: %0d changes while stalled, want 0", hold_viol); end
  endtask

  task automatic test_bad_bank;
    sel_seen = '0;
    tx_cnt = 0;
    wr_frame(8'h07, 32'h10, 32'h11223344, 8, 1'b1);
    wr_frame(8'h8F, 32'h10, 32'h55667788, 8, 1'b1);
    checks++;
    if (got_a.size() != 0 || tx_cnt != 0 || sel_seen !== '0) begin
      errors++;
      $display("FAIL bad_bank: strobes=%0d tx_cycles=%0d sel=%b want 0 0 0000", got_a.size(), tx_cnt, sel_seen);
    end
  endtask

  task automatic test_abort;
    wr_frame(8'h01, 32'h40, 32'hCAFEF00D, 2, 1'b1);
    checks++;
    if (got_a.size() != 0 || bank_select !== '0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_partial: strobes=%0d sel=%b txv=%b want 0 0000 0", got_a.size(), bank_select, tx_valid);
    end
    wr_frame(8'h02, 32'h50, 32'hA5A5A5A5, 3, 1'b0);
    rx_byte = 8'h5A;
    rx_valid = 1'b1;
    frame_active = 1'b0;
    tick;
    rx_valid = 1'b0;
    tick; tick;
    checks++;
    if (got_a.size() != 0 || bank_select !== '0) begin
      errors++;
      $display("FAIL abort_same_cycle: strobes=%0d sel=%b want 0 0000", got_a.size(), bank_select);
    end
    wr_frame(8'h03, 32'h80, 32'h12345678, 4, 1'b1);
    checks++;
    if (got_a.size() != 1) begin
      errors++;
      $display("FAIL abort_recover: strobes=%0d want 1", got_a.size());
    end else if (got_a[0] !== 32'h80 || got_d[0] !== 32'h12345678 || got_s[0] !== 4'b1000) begin
      errors++;
      $display("FAIL abort_recover_data: addr=%h wdata=%h sel=%b want 00000080 12345678 1000", got_a[0], got_d[0], got_s[0]);
    end
  endtask

  task automatic test_wrap;
    wr_frame(8'h00, 32'hFFFFFFFC, 32'($urandom), 8, 1'b1);
    checks++;
    if (got_a.size() != 2) begin
      errors++;
      $display("FAIL wrap_count: strobes=%0d want 2", got_a.size());
    end else foreach (exp_a[i]) begin
      checks++;
      if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i] || got_s[i] !== exp_s[i]) begin
        errors++;
        $display("FAIL wrap_word%0d: addr=%h wdata=%h sel=%b want %h %h %b", i, got_a[i], got_d[i], got_s[i], exp_a[i], exp_d[i], exp_s[i]);
      end
    end
    checks++;
    if (address !== 32'h4) begin errors++; $display("FAIL wrap_final_addr: got %h want 00000004", address); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] bank;
    logic [31:0] addr;
    for (int f = 0; f < 10; f++) begin
      addr = {$urandom, 2'b00};
      if ($urandom_range(0, 1) == 1) begin
        bank = 4'($urandom_range(0, NB - 1));
        rd_frame(bank, addr, $urandom_range(1, 3));
        checks++;
        if (got_tx.size() != exp_tx.size()) begin
          errors++;
          $display("FAIL b2b_rd%0d_count: got %0d want %0d", f, got_tx.size(), exp_tx.size());
        end else foreach (exp_tx[i]) if (got_tx[i] !== exp_tx[i]) begin
          errors++;
          $display("FAIL b2b_rd%0d_byte%0d: got %h want %h", f, i, got_tx[i], exp_tx[i]);
        end
      end else begin
        bank = 4'($urandom_range(0, NB + 1));
        wr_frame({4'($urandom_range(0, 7)), bank}, addr, 32'($urandom), $urandom_range(0, 10), 1'b1);
        checks++;
        if (got_a.size() != exp_a.size() || got_tx.size() != 0) begin
          errors++;
          $display("FAIL b2b_wr%0d_count: strobes=%0d tx=%0d want %0d 0", f, got_a.size(), got_tx.size(), exp_a.size());
        end else foreach (exp_a[i])
          if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i] || got_s[i] !== exp_s[i]) begin
            errors++;
            $display("FAIL b2b_wr%0d_word%0d: addr=%h wdata=%h sel=%b want %h %h %b", f, i, got_a[i], got_d[i], got_s[i], exp_a[i], exp_d[i], exp_s[i]);
          end
      end
    end
    checks++;
    if (hold_viol != 0) begin errors++; $display("FAIL b2b_hold: %0d changes while stalled, want 0", hold_viol); end
  endtask

  task automatic test_async_reset;
    int t;
    clr();
    tx_ready = 1'b0;
    frame_active = 1'b1;
    send(8'h81);
    for (int i = 0; i < 4; i++) send(8'(i == 2 ? 1 : 0));
    t = 0;
    while (tx_valid !== 1'b1 && t < 10) begin tick; t++; end
    checks++;
    if (tx_valid !== 1'b1) begin errors++; $display("FAIL arst_setup: tx_valid=%b want 1", tx_valid); end
    #3;
    resetn = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || address !== '0 || bank_select !== '0 || write_strobe !== 1'b0) begin
      errors++;
      $display("FAIL arst_immediate: txv=%b addr=%h sel=%b ws=%b want 0 0 0 0", tx_valid, address, bank_select, write_strobe);
    end
    frame_active = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    tick;
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_bad_bank;
    test_abort;
    test_wrap;
    test_back_to_back;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
